// File: rtl/muler_pkg.sv
// Shared types and mode decode for the pipelined integer multiplier.
package muler_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHU  = 2'd2,
        MULHSU = 2'd3
    } mul_mode_t;

    function automatic logic mode_is_high(mul_mode_t op);
        return op != MUL;
    endfunction

    function automatic logic mode_a_signed(mul_mode_t op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic mode_b_signed(mul_mode_t op);
        return op == MULH;
    endfunction

endpackage

// File: rtl/muler_pp_slice.sv
// One registered partial product: signed (WIDTH+1)-bit operand a times one slice of b.
module muler_pp_slice #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 16,
    parameter int TOP     = 0,
    localparam int BW     = SLICE_W + TOP,
    localparam int PPW    = WIDTH + SLICE_W + 1 + TOP
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH:0]   a_ext,
    input  logic [BW-1:0]    b_slice,
    output logic [PPW-1:0]   pp
);

    logic signed [PPW-1:0] a_w, b_w, prod;

    // Only the top slice carries b's sign; lower slices are plain magnitudes.
    assign a_w  = {{(PPW-WIDTH-1){a_ext[WIDTH]}}, a_ext};
    assign b_w  = {{(PPW-BW){(TOP != 0) ? b_slice[BW-1] : 1'b0}}, b_slice};
    assign prod = a_w * b_w;

    always_ff @(posedge clk) begin
        if (en) pp <= prod;
    end

endmodule

// File: rtl/muler_pipe.sv
// Two-stage pipelined integer multiplier: sliced partial products in M1, sum and
// half-select in M2, with stall, bubble and flush handling on the valid bits.
module muler_pipe
    import muler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SPLIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] r0_i,
    input  logic [WIDTH-1:0] r1_i,
    input  logic             m1_stall_i,
    input  logic             m2_stall_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o
);

    localparam int SLICE_W = WIDTH / SPLIT;
    localparam int PPMAX   = WIDTH + SLICE_W + 2;
    localparam int FW      = 2 * WIDTH;
    localparam int SW      = (PPMAX > FW) ? PPMAX : FW;

    mul_mode_t  op;
    logic [WIDTH:0] a_ext, b_ext;
    logic [SPLIT-1:0][PPMAX-1:0] pp_x;
    logic       s1_valid, s1_high;
    logic [SW-1:0] acc;
    logic [FW-1:0] full;

    assign op    = mul_mode_t'(op_i);
    assign a_ext = {r0_i[WIDTH-1] & mode_a_signed(op), r0_i};
    assign b_ext = {r1_i[WIDTH-1] & mode_b_signed(op), r1_i};

    for (genvar k = 0; k < SPLIT; k++) begin : g_slice
        localparam int TOP = (k == SPLIT - 1) ? 1 : 0;
        localparam int BW  = SLICE_W + TOP;
        localparam int PPW = WIDTH + SLICE_W + 1 + TOP;
        logic [PPW-1:0] pp;

        muler_pp_slice #(.WIDTH(WIDTH), .SLICE_W(SLICE_W), .TOP(TOP)) u_pp (
            .clk     (clk),
            .en      (!m1_stall_i),
            .a_ext   (a_ext),
            .b_slice (b_ext[k*SLICE_W +: BW]),
            .pp      (pp)
        );

        assign pp_x[k] = PPMAX'($signed(pp));
    end

    always_ff @(posedge clk) begin
        if (!m1_stall_i) s1_high <= mode_is_high(op);
    end

    // Every slice is sign-extended to the full width before the shift so the
    // most-negative operand pairs wrap correctly modulo 2^(2W).
    always_comb begin
        acc = '0;
        for (int i = 0; i < SPLIT; i++)
            acc = acc + (SW'($signed(pp_x[i])) << (i * SLICE_W));
    end

    assign full = acc[FW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
        end else begin
            if (flush_i)          s1_valid <= 1'b0;
            else if (!m1_stall_i) s1_valid <= valid_i;

            // A stalled M1 with a free M2 inserts a bubble: valid drops, data holds.
            if (flush_i)          result_valid_o <= 1'b0;
            else if (!m2_stall_i) result_valid_o <= s1_valid & !m1_stall_i;

            if (!m2_stall_i && !m1_stall_i)
                result_o <= s1_high ? full[FW-1:WIDTH] : full[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_muler_pipe.sv
// Directed-vector bench for muler_pipe at 32/2, 16/4 and 64/4 configurations.
module tb_muler_pipe;
    import muler_pkg::*;

    logic        clk, rst_n, valid, m1s, m2s, flush;
    logic [1:0]  op;
    logic [63:0] a, b;
    logic [31:0] res32;
    logic [15:0] res16;
    logic [63:0] res64;
    logic        vld32, vld16, vld64;
    int          n_vec = 0, n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e;
    } vec_t;
    vec_t q[$];

    muler_pipe #(.WIDTH(32), .SPLIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .op_i(op), .r0_i(a[31:0]), .r1_i(b[31:0]),
        .m1_stall_i(m1s), .m2_stall_i(m2s), .flush_i(flush), .result_o(res32), .result_valid_o(vld32));

    muler_pipe #(.WIDTH(16), .SPLIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .op_i(op), .r0_i(a[15:0]), .r1_i(b[15:0]),
        .m1_stall_i(m1s), .m2_stall_i(m2s), .flush_i(flush), .result_o(res16), .result_valid_o(vld16));

    muler_pipe #(.WIDTH(64), .SPLIT(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .op_i(op), .r0_i(a), .r1_i(b),
        .m1_stall_i(m1s), .m2_stall_i(m2s), .flush_i(flush), .result_o(res64), .result_valid_o(vld64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n) assert (!(m2s && !m1s)) else $error("stall contract violated");

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        valid = v; op = o; a = x; b = y;
    endtask

    function automatic logic [63:0] res_of(input int sel);
        case (sel)
            0:       return {32'h0, res32};
            1:       return {48'h0, res16};
            default: return res64;
        endcase
    endfunction

    function automatic logic vld_of(input int sel);
        case (sel)
            0:       return vld32;
            1:       return vld16;
            default: return vld64;
        endcase
    endfunction

    // Issue the queued vectors back-to-back; each result is due two edges after issue.
    task automatic run_b2b(input int sel, input string tag);
        for (int i = 0; i <= q.size(); i++) begin
            if (i < q.size()) drive(1'b1, q[i].op, q[i].a, q[i].b);
            else              valid = 1'b0;
            tick();
            if (i >= 1) begin
                chk($sformatf("%s_res%0d", tag, i-1), res_of(sel), q[i-1].e);
                chk($sformatf("%s_vld%0d", tag, i-1), {63'h0, vld_of(sel)}, 64'h1);
            end
        end
        tick();
        chk($sformatf("%s_tail_vld", tag), {63'h0, vld_of(sel)}, 64'h0);
        q.delete();
    endtask

    initial begin
        rst_n = 1'b0; m1s = 1'b0; m2s = 1'b0; flush = 1'b0;
        drive(1'b0, MUL, 64'h0, 64'h0);
        #12;
        chk("rst_res32", {32'h0, res32}, 64'h0);
        chk("rst_vld32", {63'h0, vld32}, 64'h0);
        chk("rst_vld16", {63'h0, vld16}, 64'h0);
        chk("rst_vld64", {63'h0, vld64}, 64'h0);
        tick();
        rst_n = 1'b1;

        // Single op, exact latency
        drive(1'b1, MUL, 64'h3, 64'h5);
        tick();
        chk("t1_vld_e1", {63'h0, vld32}, 64'h0);
        valid = 1'b0;
        tick();
        chk("t1_res", {32'h0, res32}, 64'hF);
        chk("t1_vld_e2", {63'h0, vld32}, 64'h1);
        tick();
        chk("t1_vld_e3", {63'h0, vld32}, 64'h0);

        // Mode sweep and most-negative corners, back-to-back
        q.push_back('{MUL,    64'hFFFFFFFF, 64'h2,        64'hFFFFFFFE});
        q.push_back('{MULH,   64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF});
        q.push_back('{MULHU,  64'hFFFFFFFF, 64'h2,        64'h00000001});
        q.push_back('{MULHSU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF});
        q.push_back('{MULH,   64'h80000000, 64'h80000000, 64'h40000000});
        q.push_back('{MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF});
        q.push_back('{MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE});
        q.push_back('{MUL,    64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001});
        q.push_back('{MULH,   64'h80000000, 64'h7FFFFFFF, 64'hC0000000});
        run_b2b(0, "b2b32");

        // Full stall while the result sits in M2: frozen
        drive(1'b1, MUL, 64'd7, 64'd6);
        tick();
        drive(1'b0, MUL, 64'h0, 64'h0);
        tick();
        chk("st2_res", {32'h0, res32}, 64'h2A);
        m1s = 1'b1; m2s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("st2_hold_res%0d", i), {32'h0, res32}, 64'h2A);
            chk($sformatf("st2_hold_vld%0d", i), {63'h0, vld32}, 64'h1);
        end
        m1s = 1'b0; m2s = 1'b0;
        tick();
        chk("st2_after_vld", {63'h0, vld32}, 64'h0);
        chk("st2_after_res", {32'h0, res32}, 64'h0);

        // Full stall while the op sits in M1: three cycles late
        drive(1'b1, MUL, 64'd7, 64'd6);
        tick();
        drive(1'b0, MUL, 64'h0, 64'h0);
        m1s = 1'b1; m2s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("st1_vld%0d", i), {63'h0, vld32}, 64'h0);
            chk($sformatf("st1_res%0d", i), {32'h0, res32}, 64'h0);
        end
        m1s = 1'b0; m2s = 1'b0;
        tick();
        chk("st1_late_res", {32'h0, res32}, 64'h2A);
        chk("st1_late_vld", {63'h0, vld32}, 64'h1);
        tick();
        chk("st1_end_vld", {63'h0, vld32}, 64'h0);

        // M1-only stall: one bubble, no duplicate
        drive(1'b1, MUL, 64'd7, 64'd6);
        tick();
        drive(1'b0, MUL, 64'h0, 64'h0);
        m1s = 1'b1;
        tick();
        chk("bub_vld", {63'h0, vld32}, 64'h0);
        chk("bub_res", {32'h0, res32}, 64'h0);
        m1s = 1'b0;
        tick();
        chk("bub_out_res", {32'h0, res32}, 64'h2A);
        chk("bub_out_vld", {63'h0, vld32}, 64'h1);
        tick();
        chk("bub_nodup_vld", {63'h0, vld32}, 64'h0);

        // Flush kills the op in M1 and the one presented alongside it
        drive(1'b1, MUL, 64'd2, 64'd3);
        tick();
        drive(1'b1, MUL, 64'd9, 64'd9);
        flush = 1'b1;
        tick();
        chk("fl_a_vld", {63'h0, vld32}, 64'h0);
        flush = 1'b0;
        drive(1'b1, MUL, 64'd4, 64'd5);
        tick();
        chk("fl_b_vld", {63'h0, vld32}, 64'h0);
        drive(1'b0, MUL, 64'h0, 64'h0);
        tick();
        chk("fl_c_res", {32'h0, res32}, 64'h14);
        chk("fl_c_vld", {63'h0, vld32}, 64'h1);
        m1s = 1'b1; m2s = 1'b1; flush = 1'b1;
        tick();
        chk("fl_stall_vld", {63'h0, vld32}, 64'h0);
        chk("fl_stall_res", {32'h0, res32}, 64'h14);
        m1s = 1'b0; m2s = 1'b0; flush = 1'b0;
        tick();
        chk("fl_end_vld", {63'h0, vld32}, 64'h0);

        // Asynchronous reset mid-operation
        drive(1'b1, MUL, 64'd7, 64'd6);
        tick();
        tick();
        chk("rs_pre_res", {32'h0, res32}, 64'h2A);
        rst_n = 1'b0;
        #1;
        chk("rs_async_res", {32'h0, res32}, 64'h0);
        chk("rs_async_vld", {63'h0, vld32}, 64'h0);
        valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_rel_vld0", {63'h0, vld32}, 64'h0);
        tick();
        chk("rs_rel_vld1", {63'h0, vld32}, 64'h0);

        // WIDTH=16, SPLIT=4
        q.push_back('{MUL,    64'h1234, 64'h0010, 64'h2340});
        q.push_back('{MULH,   64'hFFFF, 64'h0002, 64'hFFFF});
        q.push_back('{MULHU,  64'hFFFF, 64'h0002, 64'h0001});
        q.push_back('{MULHSU, 64'hFFFF, 64'h0002, 64'hFFFF});
        q.push_back('{MULH,   64'h8000, 64'h8000, 64'h4000});
        q.push_back('{MULHSU, 64'hFFFF, 64'hFFFF, 64'hFFFF});
        q.push_back('{MULHU,  64'hFFFF, 64'hFFFF, 64'hFFFE});
        q.push_back('{MULHSU, 64'h8000, 64'hFFFF, 64'h8000});
        q.push_back('{MULH,   64'h7FFF, 64'h7FFF, 64'h3FFF});
        run_b2b(1, "w16");

        // WIDTH=64, SPLIT=4
        q.push_back('{MULH,   64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000});
        q.push_back('{MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE});
        q.push_back('{MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF});
        q.push_back('{MUL,    64'h0000000100000000, 64'h0000000100000000, 64'h0});
        q.push_back('{MULHU,  64'h0000000100000000, 64'h0000000100000000, 64'h1});
        q.push_back('{MULHSU, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000});
        q.push_back('{MUL,    64'h0000000123456789, 64'h10,               64'h0000001234567890});
        q.push_back('{MUL,    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h1});
        run_b2b(2, "w64");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
